// File: rtl/pes_fp_pkg.sv
// Shared field-width helpers, operand classes and flag layout for the parametrised
// floating-point multiplier pipe.
package pes_fp_pkg;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } fp_cls_e;

  // Bit positions inside the 4-bit flags word {invalid, overflow, underflow, inexact}.
  localparam int FLG_INEXACT   = 0;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_OVERFLOW  = 2;
  localparam int FLG_INVALID   = 3;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int fp_width(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  // Quiet NaN: sign 0, exponent all ones, fraction MSB set; caller keeps the low W bits.
  function automatic logic [127:0] fp_canon_nan(input int exp_w, input int man_w);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < exp_w; i++) r = r | (128'(1) << (man_w + i));
    r = r | (128'(1) << (man_w - 1));
    return r;
  endfunction

endpackage

// File: rtl/pes_fpmul_pipe_if.sv
// Operand/result bundle of the multiplier pipe.
// Valid/ready: a beat transfers on a rising edge with valid && ready; the sender keeps valid and
// payload stable until it transfers, and ready may depend combinationally on downstream ready.
interface pes_fpmul_pipe_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] f;
  logic [3:0]   flags;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, f, flags
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, f, flags
  );
endinterface

// File: rtl/pes_fp_round_pack.sv
// Round-to-nearest-even, range check and packing of a normalised product, with special-class
// override; purely combinational, registered by the caller.
module pes_fp_round_pack
  import pes_fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     sign_i,
  input  logic signed [EXP_W+1:0]  e_i,
  input  logic [MAN_W-1:0]         frac_i,
  input  logic                     guard_i,
  input  logic                     sticky_i,
  input  fp_cls_e                  cls_i,
  input  logic                     invalid_i,
  output logic [EXP_W+MAN_W:0]     f_o,
  output logic [3:0]               flags_o
);
  localparam int W  = fp_width(EXP_W, MAN_W);
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] E_MAX  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] E_ZERO = '0;
  localparam logic [127:0] NAN_WIDE = fp_canon_nan(EXP_W, MAN_W);

  logic                 rnd_up;
  logic [MAN_W:0]       frac_sum;
  logic signed [EW-1:0] e_r;

  assign rnd_up   = guard_i && (sticky_i || frac_i[0]);
  assign frac_sum = {1'b0, frac_i} + {{MAN_W{1'b0}}, rnd_up};
  // A carry out of the fraction leaves it at zero and bumps the exponent.
  assign e_r      = e_i + $signed({{(EW-1){1'b0}}, frac_sum[MAN_W]});

  always_comb begin
    f_o     = '0;
    flags_o = '0;
    case (cls_i)
      CLS_NAN: begin
        f_o                  = NAN_WIDE[W-1:0];
        flags_o[FLG_INVALID] = invalid_i;
      end
      CLS_INF:  f_o = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      CLS_ZERO: f_o = {sign_i, {(EXP_W+MAN_W){1'b0}}};
      default: begin
        if (e_r >= E_MAX) begin
          f_o                    = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flags_o[FLG_OVERFLOW]  = 1'b1;
          flags_o[FLG_INEXACT]   = 1'b1;
        end else if (e_r <= E_ZERO) begin
          f_o                    = {sign_i, {(EXP_W+MAN_W){1'b0}}};
          flags_o[FLG_UNDERFLOW] = 1'b1;
          flags_o[FLG_INEXACT]   = 1'b1;
        end else begin
          f_o                    = {sign_i, e_r[EXP_W-1:0], frac_sum[MAN_W-1:0]};
          flags_o[FLG_INEXACT]   = guard_i | sticky_i;
        end
      end
    endcase
  end

endmodule

// File: rtl/pes_fpmul_pipe.sv
// Four-stage floating-point multiplier with valid/ready back-pressure:
// S1 unpack/classify, S2 multiply, S3 normalise, S4 round/pack into the output register.
module pes_fpmul_pipe
  import pes_fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic             clk,
  input  logic             rst,
  pes_fpmul_pipe_if.slave  bus
);
  localparam int W  = fp_width(EXP_W, MAN_W);
  localparam int MW = MAN_W + 1;
  localparam int PW = 2 * MW;
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] BIAS = EW'(fp_bias(EXP_W));

  function automatic fp_cls_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
    if (e == '0) return CLS_ZERO;
    if (&e) return (m == '0) ? CLS_INF : CLS_NAN;
    return CLS_NORM;
  endfunction

  // Each stage can take new data when empty or when its own content moves on.
  logic v1_q, v2_q, v3_q, v4_q;
  logic rdy1, rdy2, rdy3, rdy4;
  assign rdy4 = !v4_q || bus.out_ready;
  assign rdy3 = !v3_q || rdy4;
  assign rdy2 = !v2_q || rdy3;
  assign rdy1 = !v1_q || rdy2;
  assign bus.in_ready = rdy1;

  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  fp_cls_e          ca, cb;
  assign ea = bus.a[W-2 -: EXP_W];
  assign eb = bus.b[W-2 -: EXP_W];
  assign fa = bus.a[MAN_W-1:0];
  assign fb = bus.b[MAN_W-1:0];
  assign ca = classify(ea, fa);
  assign cb = classify(eb, fb);

  fp_cls_e s1_cls_d;
  logic    s1_inv_d;
  always_comb begin
    s1_cls_d = CLS_NORM;
    s1_inv_d = 1'b0;
    if (ca == CLS_NAN || cb == CLS_NAN) begin
      s1_cls_d = CLS_NAN;
    end else if ((ca == CLS_INF && cb == CLS_ZERO) || (ca == CLS_ZERO && cb == CLS_INF)) begin
      s1_cls_d = CLS_NAN;
      s1_inv_d = 1'b1;
    end else if (ca == CLS_INF || cb == CLS_INF) begin
      s1_cls_d = CLS_INF;
    end else if (ca == CLS_ZERO || cb == CLS_ZERO) begin
      s1_cls_d = CLS_ZERO;
    end
  end

  logic             s1_sign_q, s1_inv_q;
  fp_cls_e          s1_cls_q;
  logic [EXP_W-1:0] s1_ea_q, s1_eb_q;
  logic [MW-1:0]    s1_ma_q, s1_mb_q;

  logic [PW-1:0]        s2_prod_d, s2_prod_q;
  logic signed [EW-1:0] s2_e_d, s2_e_q;
  logic                 s2_sign_q, s2_inv_q;
  fp_cls_e              s2_cls_q;
  assign s2_prod_d = PW'(s1_ma_q) * PW'(s1_mb_q);
  assign s2_e_d    = $signed({2'b00, s1_ea_q}) + $signed({2'b00, s1_eb_q}) - BIAS;

  // Product lies in [1,4); a set MSB means one extra integer bit to shift out.
  logic                 s2_msb;
  logic [MAN_W-1:0]     s3_frac_d, s3_frac_q;
  logic                 s3_guard_d, s3_guard_q, s3_sticky_d, s3_sticky_q;
  logic signed [EW-1:0] s3_e_d, s3_e_q;
  logic                 s3_sign_q, s3_inv_q;
  fp_cls_e              s3_cls_q;
  assign s2_msb      = s2_prod_q[PW-1];
  assign s3_frac_d   = s2_msb ? s2_prod_q[PW-2 -: MAN_W] : s2_prod_q[PW-3 -: MAN_W];
  assign s3_guard_d  = s2_msb ? s2_prod_q[MAN_W] : s2_prod_q[MAN_W-1];
  assign s3_sticky_d = s2_msb ? |s2_prod_q[MAN_W-1:0] : |s2_prod_q[MAN_W-2:0];
  assign s3_e_d      = s2_e_q + $signed({{(EW-1){1'b0}}, s2_msb});

  logic [W-1:0] f_d, f_q;
  logic [3:0]   flags_d, flags_q;

  pes_fp_round_pack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round_pack (
    .sign_i    (s3_sign_q),
    .e_i       (s3_e_q),
    .frac_i    (s3_frac_q),
    .guard_i   (s3_guard_q),
    .sticky_i  (s3_sticky_q),
    .cls_i     (s3_cls_q),
    .invalid_i (s3_inv_q),
    .f_o       (f_d),
    .flags_o   (flags_d)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      v4_q    <= 1'b0;
      f_q     <= '0;
      flags_q <= '0;
    end else begin
      if (rdy1) v1_q <= bus.in_valid;
      if (rdy2) v2_q <= v1_q;
      if (rdy3) v3_q <= v2_q;
      if (rdy4) v4_q <= v3_q;
      if (rdy4 && v3_q) begin
        f_q     <= f_d;
        flags_q <= flags_d;
      end
    end
  end

  // Payload registers only move with a valid beat and need no reset.
  always_ff @(posedge clk) begin
    if (bus.in_valid && rdy1) begin
      s1_sign_q <= bus.a[W-1] ^ bus.b[W-1];
      s1_cls_q  <= s1_cls_d;
      s1_inv_q  <= s1_inv_d;
      s1_ea_q   <= ea;
      s1_eb_q   <= eb;
      s1_ma_q   <= {1'b1, fa};
      s1_mb_q   <= {1'b1, fb};
    end
    if (v1_q && rdy2) begin
      s2_prod_q <= s2_prod_d;
      s2_e_q    <= s2_e_d;
      s2_sign_q <= s1_sign_q;
      s2_cls_q  <= s1_cls_q;
      s2_inv_q  <= s1_inv_q;
    end
    if (v2_q && rdy3) begin
      s3_frac_q   <= s3_frac_d;
      s3_guard_q  <= s3_guard_d;
      s3_sticky_q <= s3_sticky_d;
      s3_e_q      <= s3_e_d;
      s3_sign_q   <= s2_sign_q;
      s3_cls_q    <= s2_cls_q;
      s3_inv_q    <= s2_inv_q;
    end
  end

  assign bus.out_valid = v4_q;
  assign bus.f         = f_q;
  assign bus.flags     = flags_q;

endmodule

// File: doc/pes_fpmul_pipe.md
Name: pes_fpmul_pipe

Overview:
Parametrised, fully pipelined IEEE-754-style floating-point multiplier, the next generation of our fixed single-precision pipe multiplier. It adds:
- configurable exponent/mantissa widths;
- valid/ready flow control with back-pressure;
- correct sign XOR and round-to-nearest-even;
- zero/Inf/NaN handling, overflow/underflow saturation and exception flags.

It sits between operand-issue logic and the result writeback/accumulate stage of the datapath.

Parameters:
EXP_W, 8, exponent field width (≥3); bias = 2^(EXP_W-1)-1, derived internally.
MAN_W, 23, stored fraction width (≥2); operand/result width W = 1+EXP_W+MAN_W.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, synchronous, active-low
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept operands this cycle
a  in  W  operand A {sign, exp, frac}
b  in  W  operand B
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result this cycle
f  out  W  product
flags  out  4  {invalid, overflow, underflow, inexact}, aligned with f

Behaviour:
- Reset: rst==0 at a clk edge clears all stage valid bits. out_valid=0, f=0, flags=0. Data registers need not be cleared. Reset mid-operation discards all in-flight results; in_ready=1 on the first cycle after reset release.
- Pipeline: 4 stages, each with a valid bit. A transfer occurs when in_valid&&in_ready; the result appears with out_valid=1 exactly 4 cycles later if not stalled.
- Stage k advances iff its successor is empty or advancing; output stage advances iff out_ready. in_ready = !v1 || stage1 advancing (combinational from out_ready chain). Full throughput: one op/cycle while out_ready=1.
- While out_valid && !out_ready: f and flags are held stable. No data loss, no duplication, strict in-order delivery.
- S1 unpack/classify:
  - sign = sa^sb.
  - Exp==0: treated as zero; subnormal inputs are flushed (DAZ).
  - Exp all-ones: frac==0 → Inf, else NaN.
  - Hidden 1 prepended for normals.
- S2: (MAN_W+1)x(MAN_W+1) unsigned multiply → 2*MAN_W+2-bit product. Signed exponent e = ea+eb-bias, computed in EXP_W+2 bits.
- S3 normalise: product in [1,4). If MSB set, shift right 1 and e+=1. Form guard bit and sticky (OR of all remaining bits).
- S4 round/pack (RNE):
  - Round up iff guard && (sticky || lsb).
  - Carry-out of rounding → fraction 0, e+=1.
  - Final e ≥ 2^EXP_W-1 → ±Inf, overflow=1, inexact=1.
  - Final e ≤ 0 → ±0 (flush), underflow=1, inexact=1.
  - Otherwise inexact = guard|sticky.
- Specials (override S2–S4 arithmetic, carried as class bits):
  - Any NaN, or Inf×0 → canonical qNaN (sign 0, exp all-ones, frac MSB=1, rest 0). invalid=1 only for Inf×0; NaN input alone gives no flag.
  - Inf×finite-nonzero or Inf×Inf → signed Inf, no flags.
  - Zero×finite → signed zero, no flags.
- Flags are per-result, not sticky.

Decomposition:
- Shared package pes_fp_pkg:
  - Field-width functions: bias, W.
  - Operand class enum: ZERO, NORM, INF, NAN.
  - Flag bit index constants.
  - Canonical-NaN constant function.
- Natural sub-module pes_fp_round_pack, used by S4: takes sign, e, normalised mantissa, guard, sticky and class; returns packed f and flags.
- Stage-valid/ready logic stays in the top module.

Test Plan:
1. a=0x3FC00000 (1.5), b=0x40000000 (2.0) → f=0x40400000, flags=0, out_valid exactly 4 cycles after accept.
2. a=0xC0000000, b=0x40400000 → f=0xC0C00000. Also a=0x3F800001, b=0x3F800001 → f=0x3F800002, flags=0001 (inexact, RNE).
3. a=0x7F000000, b=0x7F000000 → f=0x7F800000, flags=0101. a=0x00800000, b=0x3F000000 → f=0x00000000, flags=0011.
4. a=0x7F800000, b=0x00000000 → f=0x7FC00000, flags=1000. a=0xFF800000, b=0x40000000 → f=0xFF800000, flags=0.
5. Six back-to-back valid inputs with out_ready=0 for cycles 3–8 → in_ready falls after 4 stages fill. All 6 results delivered in order, none lost or duplicated, f held stable while stalled.
6. rst=0 for one cycle with 3 ops in flight → next cycle out_valid=0, f=0, flags=0. No stale result emerges; a new op afterwards completes normally. Repeat 1–4 with EXP_W=5, MAN_W=10: 0x3E00×0x4000 → 0x4200.
